pixel_write_buffer: RTL and testbench

- Downstream stage of the line-drawing datapath. It accepts plot requests (x, y, colour) at up to one per cycle and buffers them in a FIFO.
- It converts each request to a linear framebuffer address (y*SCREEN_W + x) and issues single-cycle writes to the VGA adapter's video memory port.
- It also provides a clear-screen sweep, so the line FSM never stalls on memory timing and never clears the screen itself.

---
 rtl/pixel_write_buffer_pkg.sv | 16 +
 rtl/pixel_write_buffer_fifo.sv | 36 +++
 rtl/pixel_write_buffer.sv | 90 +++++++++
 tb/tb_pixel_write_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_write_buffer_pkg.sv
// pixel_write_buffer_pkg: shared framebuffer geometry, FSM states and pixel request type.
package pixel_write_buffer_pkg;
   localparam int SCREEN_W = 320;
   localparam int SCREEN_H = 240;
   localparam int FB_PIXELS = SCREEN_W * SCREEN_H;
   localparam int ADDR_W = 17;
   localparam int X_W = 9;
   localparam int Y_W = 8;
   localparam int COLOUR_W = 3;
   typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;
   typedef struct packed {
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
      logic [COLOUR_W-1:0] colour;
   } pixel_t;
endpackage

// File: rtl/pixel_write_buffer_fifo.sv
// sync_fifo: synchronous FIFO with registered read data (one-cycle pop latency).
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   assign level = wr_ptr - rd_ptr;
   assign empty = wr_ptr == rd_ptr;
   assign full = level == (AW+1)'(DEPTH);
   always_ff @(posedge clk)
      if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         pop_data <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + 1'b1;
            pop_data <= mem[rd_ptr[AW-1:0]];
         end
      end
endmodule

// File: rtl/pixel_write_buffer.sv
// pixel_write_buffer: buffers plot requests, issues linear framebuffer writes and runs clear sweeps.
// Define PIXEL_CLIP_EN to drop out-of-range pixels and count them in drop_cnt.
module pixel_write_buffer #(
   parameter int FIFO_DEPTH = 16,
   parameter int SCREEN_W = pixel_write_buffer_pkg::SCREEN_W,
   parameter int SCREEN_H = pixel_write_buffer_pkg::SCREEN_H,
   parameter int COLOUR_W = pixel_write_buffer_pkg::COLOUR_W
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [8:0]                    in_x,
   input  logic [7:0]                    in_y,
   input  logic [COLOUR_W-1:0]           in_colour,
   input  logic                          clear_req,
   input  logic [COLOUR_W-1:0]           clear_colour,
   output logic                          busy,
   output logic                          mem_we,
   output logic [16:0]                   mem_addr,
   output logic [COLOUR_W-1:0]           mem_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [15:0]                   drop_cnt
);
   import pixel_write_buffer_pkg::state_t, pixel_write_buffer_pkg::RUN;
   import pixel_write_buffer_pkg::DRAIN, pixel_write_buffer_pkg::CLEAR;
   import pixel_write_buffer_pkg::ADDR_W, pixel_write_buffer_pkg::X_W, pixel_write_buffer_pkg::Y_W;
   localparam int PIXELS = SCREEN_W * SCREEN_H;
   typedef struct packed {
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
      logic [COLOUR_W-1:0] colour;
   } req_t;
   state_t state, state_nx;
   req_t head;
   logic ready_en, fifo_full, fifo_empty, pop, a_v, in_range, drained;
   logic [COLOUR_W-1:0] clr_colour;
   logic [ADDR_W-1:0] cnt, addr_a;
   assign in_ready = ready_en && !fifo_full && state == RUN && !clear_req;
   assign pop = !fifo_empty && state != CLEAR;
   assign drained = fifo_empty && !a_v && !mem_we;
   assign busy = fifo_level != '0 || a_v || mem_we || state != RUN;
   assign addr_a = ADDR_W'(head.y) * ADDR_W'(SCREEN_W) + ADDR_W'(head.x);
   // The FIFO output register doubles as stage A; stage B is the memory port register.
   sync_fifo #(.WIDTH($bits(req_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk,
      .reset,
      .push(in_valid && in_ready),
      .push_data({in_x, in_y, in_colour}),
      .pop,
      .pop_data(head),
      .full(fifo_full),
      .empty(fifo_empty),
      .level(fifo_level)
   );
   always_comb begin
      state_nx = state == RUN ? (clear_req ? DRAIN : RUN) :
                 state == DRAIN ? (drained ? CLEAR : DRAIN) :
                 (cnt == ADDR_W'(PIXELS - 1) ? RUN : CLEAR);
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= RUN;
         ready_en <= 1'b0;
         a_v <= 1'b0;
         cnt <= '0;
         clr_colour <= '0;
         mem_we <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
      end else begin
         state <= state_nx;
         ready_en <= 1'b1;
         a_v <= pop;
         cnt <= state == CLEAR ? cnt + 1'b1 : '0;
         if (state == RUN && clear_req) clr_colour <= clear_colour;
         mem_we <= state == CLEAR || (a_v && in_range);
         mem_addr <= state == CLEAR ? cnt : addr_a;
         mem_data <= state == CLEAR ? clr_colour : head.colour;
      end
`ifdef PIXEL_CLIP_EN
   assign in_range = 32'(head.x) < SCREEN_W && 32'(head.y) < SCREEN_H;
   always_ff @(posedge clk or posedge reset)
      if (reset) drop_cnt <= '0;
      else if (a_v && !in_range && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
`else
   assign in_range = 1'b1;
   assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_pixel_write_buffer.sv
// tb_pixel_write_buffer: directed stimulus with a queue-based write-order model and literal spot checks.
module tb_pixel_write_buffer;
   logic clk = 0;
   logic reset = 1;
   logic in_valid = 0;
   logic [8:0] in_x = 0;
   logic [7:0] in_y = 0;
   logic [2:0] in_colour = 0;
   logic clear_req = 0;
   logic [2:0] clear_colour = 0;
   logic in_ready, busy, mem_we;
   logic [16:0] mem_addr;
   logic [2:0] mem_data;
   logic [4:0] fifo_level;
   logic [15:0] drop_cnt;
   typedef struct {bit clr; int addr; int data;} wr_t;
   wr_t expq[$];
   wr_t h;
   bit ok;
   int checks = 0, errors = 0, stalls = 0;
   int wr_cnt = 0, last_addr = -1, exp_drops = 0;
   int base, n, viol;

   pixel_write_buffer dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
      .clear_req(clear_req), .clear_colour(clear_colour), .busy(busy),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
      .fifo_level(fifo_level), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: every accepted pixel and accepted clear becomes an expected write run, in acceptance order.
   always @(negedge clk) begin
      if (reset) expq.delete();
      else begin
         if (mem_we) begin
            wr_cnt++;
            last_addr = int'(mem_addr);
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr=%0d data=%0d, required no write", mem_addr, mem_data);
            end else begin
               h = expq[0];
               chk("write_addr", 32'(mem_addr), h.addr);
               chk("write_data", 32'(mem_data), h.data);
               if (h.clr && h.addr < 76799) begin
                  h.addr++;
                  expq[0] = h;
               end else void'(expq.pop_front());
            end
         end
         if (in_valid && in_ready) begin
            ok = 1;
`ifdef PIXEL_CLIP_EN
            ok = in_x < 320 && in_y < 240;
`endif
            if (ok) expq.push_back('{1'b0, (int'(in_y) * 320 + int'(in_x)) % 131072, int'(in_colour)});
            else exp_drops++;
         end
         if (clear_req && !(expq.size() > 0 && expq[$].clr))
            expq.push_back('{1'b1, 0, int'(clear_colour)});
      end
   end

   task automatic drive(input int x, input int y, input int c);
      int k = 0;
      @(posedge clk) #1;
      in_valid = 1;
      in_x = 9'(x);
      in_y = 8'(y);
      in_colour = 3'(c);
      @(negedge clk);
      if (!in_ready) stalls++;
      while (!in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic stop_drive();
      @(posedge clk) #1;
      in_valid = 0;
   endtask

   task automatic pulse_clear(input int c);
      @(posedge clk) #1;
      in_valid = 0;
      clear_req = 1;
      clear_colour = 3'(c);
      @(posedge clk) #1;
      clear_req = 0;
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      @(negedge clk);
      while (busy && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk(name, 32'(busy), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_data", 32'(mem_data), 0);
      chk("rst_fifo_level", 32'(fifo_level), 0);
      chk("rst_drop_cnt", 32'(drop_cnt), 0);
      @(posedge clk) #1 reset = 0;
      @(negedge clk) chk("ready_first_cycle", 32'(in_ready), 0);
      @(negedge clk) chk("ready_second_cycle", 32'(in_ready), 1);

      // Single pixel latency: accepted on edge N, write visible after edge N+2.
      drive(5, 3, 5);
      stop_drive();
      @(negedge clk) chk("lat_n0_we", 32'(mem_we), 0);
      @(negedge clk) chk("lat_n1_we", 32'(mem_we), 0);
      @(negedge clk);
      chk("lat_n2_we", 32'(mem_we), 1);
      chk("lat_addr", 32'(mem_addr), 965);
      chk("lat_data", 32'(mem_data), 5);
      chk("lat_busy", 32'(busy), 1);
      @(negedge clk);
      chk("lat_after_we", 32'(mem_we), 0);
      chk("lat_busy_falls", 32'(busy), 0);

      base = wr_cnt;
      stalls = 0;
      for (int i = 0; i < 20; i++) drive(100 + i, 50, i % 8);
      stop_drive();
      wait_idle("burst_idle");
      chk("burst_stalls", stalls, 0);
      chk("burst_writes", wr_cnt - base, 20);
      chk("burst_last_addr", last_addr, 16119);

      drive(0, 0, 1);
      drive(319, 239, 6);
      stop_drive();
      wait_idle("corner_idle");
      chk("corner_last_addr", last_addr, 76799);

      base = wr_cnt;
      drive(320, 0, 2);
      drive(0, 240, 3);
      drive(10, 10, 4);
      stop_drive();
      wait_idle("clip_idle");
      chk("clip_last_addr", last_addr, 3210);
      chk("clip_drop_model", 32'(drop_cnt), exp_drops);
`ifdef PIXEL_CLIP_EN
      chk("clip_writes", wr_cnt - base, 1);
      chk("clip_drop_cnt", 32'(drop_cnt), 2);
`else
      chk("clip_writes", wr_cnt - base, 3);
      chk("clip_drop_cnt", 32'(drop_cnt), 0);
`endif

      base = wr_cnt;
      for (int i = 0; i < 10; i++) drive(i, 1, 7);
      pulse_clear(6);
      n = 0;
      viol = 0;
      do begin
         @(negedge clk);
         n++;
         if (in_ready && !(mem_we && mem_addr == 17'd76799)) viol++;
      end while (!(mem_we && mem_addr == 17'd76799 && mem_data == 3'd6) && n < 80000);
      chk("clear_end_addr", 32'(mem_addr), 76799);
      chk("clear_ready_high_cycles", viol, 0);
      wait_idle("clear_idle");
      chk("clear_writes", wr_cnt - base, 76810);
      chk("clear_run_resumes", 32'(in_ready), 1);

      pulse_clear(3);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(mem_we && mem_addr == 17'd1000) && n < 2000);
      chk("abort_at_1000", 32'(mem_addr), 1000);
      reset = 1;
      #1;
      chk("abort_mem_we", 32'(mem_we), 0);
      chk("abort_fifo_level", 32'(fifo_level), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_in_ready", 32'(in_ready), 0);
      repeat (2) @(posedge clk);
      #1 reset = 0;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("abort_ready_back", 32'(in_ready), 1);
      base = wr_cnt;
      drive(7, 2, 1);
      stop_drive();
      wait_idle("post_reset_idle");
      chk("post_reset_writes", wr_cnt - base, 1);
      chk("post_reset_addr", last_addr, 647);
      chk("model_drained", expq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
